// File: rtl/sz_pkg.sv
// Shared float definitions for the sz_first_stages result path: field
// positions of an IEEE-754 single and the error-bound magnitude compare.
package sz_pkg;

  localparam int          FP_W       = 32;
  localparam int          FP_EXP_MSB = 30;
  localparam int          FP_EXP_LSB = 23;
  localparam logic [7:0]  FP_EXP_INF = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  // |a| <= |b| for finite a. Sign bits are masked off, so the compare runs on
  // magnitudes; finite non-negative singles order like their bit patterns.
  // An all-ones exponent (Inf/NaN) is never within the bound.
  function automatic logic fp_abs_le(input fp32_t a, input fp32_t b);
    return (a.exp != FP_EXP_INF) &&
           ((a & 32'h7FFF_FFFF) <= (b & 32'h7FFF_FFFF));
  endfunction

endpackage

// File: rtl/sz_sync_fifo.sv
// Single-clock FIFO with an occupancy count. Read data is presented straight
// from storage at the read pointer and forced to zero while empty, so the
// output is clean after reset without resetting the storage array.
module sz_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write.
  // NOTE: the array has no reset; level and pointers decide what is valid,
  // and leaving it out keeps the storage a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; synchronous active-low reset discards all beats.
  // NOTE: state is updated with <= so every process sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  // Head of queue, zero while empty.
  // NOTE: the default comes first so no path can leave rdata unassigned.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr];
  end

endmodule

// File: rtl/fp_result_sink.sv
// AXI-Stream sink for the float-core result stream. Each accepted beat is
// tagged with "|x| <= err_bound", buffered with its tlast, and forwarded to
// the quantiser stage. Define FP_RESULT_SINK_STATS_EN to add pop counters
// split by tag, with a synchronous clear.
module fp_result_sink
  import sz_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [31:0]       err_bound,
  input  logic              s_axis_result_tvalid,
  output logic              s_axis_result_tready,
  input  logic [31:0]       s_axis_result_tdata,
  input  logic              s_axis_result_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [AW:0]       level
`ifdef FP_RESULT_SINK_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_in_bound,
  output logic [31:0]       stat_out_bound
`endif
);

  logic        aresetn_q;
  logic        push;
  logic        pop;
  logic        tag;
  logic        empty;
  logic        full;
  logic [33:0] rdata;

  // Registered copy of reset so tready is low through reset and comes only
  // from flops, never from a combinational input.
  always_ff @(posedge aclk) begin
    aresetn_q <= aresetn;
  end

  assign s_axis_result_tready = aresetn_q && !full;
  assign push = s_axis_result_tvalid && s_axis_result_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign tag  = fp_abs_le(fp32_t'(s_axis_result_tdata), fp32_t'(err_bound));

  sz_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (34)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .wdata ({s_axis_result_tlast, tag, s_axis_result_tdata}),
    .pop   (pop),
    .rdata (rdata),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  assign m_axis_tvalid = !empty;
  assign m_axis_tlast  = rdata[33];
  assign m_axis_tuser  = rdata[32];
  assign m_axis_tdata  = rdata[31:0];

`ifdef FP_RESULT_SINK_STATS_EN
  // Saturating pop counters by tag; a clear wins over a same-cycle pop.
  always_ff @(posedge aclk) begin
    if (!aresetn || stat_clr) begin
      stat_in_bound  <= '0;
      stat_out_bound <= '0;
    end else if (pop) begin
      if (m_axis_tuser && (stat_in_bound != '1))
        stat_in_bound <= stat_in_bound + 1'b1;
      if (!m_axis_tuser && (stat_out_bound != '1))
        stat_out_bound <= stat_out_bound + 1'b1;
    end
  end
`else
  // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_fp_result_sink.sv
// Self-checking bench for fp_result_sink. A queue of expected beats, a
// ready flag and tag-split counters model the sink; every negedge the DUT
// outputs are compared with the model before inputs for the next edge are set.
module tb_fp_result_sink;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] err_bound;
  logic        s_axis_result_tvalid;
  logic        s_axis_result_tready;
  logic [31:0] s_axis_result_tdata;
  logic        s_axis_result_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [AW:0] level;
  logic        stat_clr;
  logic [31:0] stat_in_bound;
  logic [31:0] stat_out_bound;

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] q[$];
  logic        m_rdy = 1'b0;
  longint      m_in  = 0;
  longint      m_out = 0;

  always #5 aclk = ~aclk;

  fp_result_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .err_bound            (err_bound),
    .s_axis_result_tvalid (s_axis_result_tvalid),
    .s_axis_result_tready (s_axis_result_tready),
    .s_axis_result_tdata  (s_axis_result_tdata),
    .s_axis_result_tlast  (s_axis_result_tlast),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tuser         (m_axis_tuser),
    .m_axis_tlast         (m_axis_tlast),
    .level                (level)
`ifdef FP_RESULT_SINK_STATS_EN
    ,
    .stat_clr             (stat_clr),
    .stat_in_bound        (stat_in_bound),
    .stat_out_bound       (stat_out_bound)
`endif
  );

  // Value-level rule: Inf/NaN are never in bound; otherwise |x| <= bound.
  function automatic logic ref_in_bound(input logic [31:0] x, input logic [31:0] b);
    logic [7:0] e;
    e = x[30:23];
    if (e == 8'hFF) return 1'b0;
    return {1'b0, x[30:0]} <= {1'b0, b[30:0]};
  endfunction

  // One clock: compare outputs against the model, drive inputs, advance model.
  task automatic drive_cycle(input logic rst_i, input logic sv, input logic [31:0] sd,
                             input logic sl, input logic mr, input logic clr,
                             output logic pushed, output logic popped,
                             output logic [33:0] pw);
    logic [33:0] ew;
    logic        er;
    @(negedge aclk);
    ew = (q.size() != 0) ? q[0] : 34'h0;
    er = m_rdy && (q.size() < DEPTH);
    n_cmp++;
    if (s_axis_result_tready !== er) begin
      n_err++; $display("FAIL s_tready: got %b want %b", s_axis_result_tready, er);
    end
    n_cmp++;
    if (m_axis_tvalid !== (q.size() != 0)) begin
      n_err++; $display("FAIL m_tvalid: got %b want %b", m_axis_tvalid, q.size() != 0);
    end
    n_cmp++;
    if (level !== (AW+1)'(q.size())) begin
      n_err++; $display("FAIL level: got %0d want %0d", level, q.size());
    end
    n_cmp++;
    if ({m_axis_tlast, m_axis_tuser, m_axis_tdata} !== ew) begin
      n_err++;
      $display("FAIL m_beat: got last=%b user=%b data=%h want last=%b user=%b data=%h",
               m_axis_tlast, m_axis_tuser, m_axis_tdata, ew[33], ew[32], ew[31:0]);
    end
`ifdef FP_RESULT_SINK_STATS_EN
    n_cmp++;
    if (stat_in_bound !== 32'(m_in) || stat_out_bound !== 32'(m_out)) begin
      n_err++;
      $display("FAIL stats: got in=%0d out=%0d want in=%0d out=%0d",
               stat_in_bound, stat_out_bound, m_in, m_out);
    end
`endif
    aresetn              = rst_i;
    s_axis_result_tvalid = sv;
    s_axis_result_tdata  = sd;
    s_axis_result_tlast  = sl;
    m_axis_tready        = mr;
    stat_clr             = clr;
    pushed = rst_i && sv && er;
    popped = rst_i && mr && (q.size() != 0);
    pw     = ew;
    if (!rst_i || clr) begin
      m_in = 0; m_out = 0;
    end else if (popped) begin
      if (ew[32]) m_in  = (m_in  < 64'hFFFF_FFFF) ? m_in  + 1 : m_in;
      else        m_out = (m_out < 64'hFFFF_FFFF) ? m_out + 1 : m_out;
    end
    if (popped) void'(q.pop_front());
    if (pushed) q.push_back({sl, ref_in_bound(sd, err_bound), sd});
    if (!rst_i) q.delete();
    m_rdy = rst_i;
  endtask

  task automatic drain();
    logic pu, po;
    logic [33:0] w;
    for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++)
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, pu, po, w);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL drain_timeout: got %0d left want 0", q.size());
    end
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pu, po, w);
  endtask

  task automatic test_reset();
    logic pu, po;
    logic [33:0] w;
    aresetn = 1'b0; s_axis_result_tvalid = 1'b0; s_axis_result_tdata = '0;
    s_axis_result_tlast = 1'b0; m_axis_tready = 1'b0; stat_clr = 1'b0;
    err_bound = 32'h3A83126F;
    repeat (2) @(posedge aclk);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pu, po, w);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pu, po, w);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pu, po, w);
    n_cmp++;
    if (s_axis_result_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || level !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got tready=%b tvalid=%b level=%0d want 1 0 0",
               s_axis_result_tready, m_axis_tvalid, level);
    end
  endtask

  task automatic test_tag();
    logic [31:0] vec [3] = '{32'hBA000000, 32'h3B000000, 32'h7FC00000};
    logic        exp_user [3] = '{1'b1, 1'b0, 1'b0};
    logic pu, po;
    logic [33:0] w;
    err_bound = 32'h3A83126F;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 1'b1, vec[i], (i == 2), 1'b0, 1'b0, pu, po, w);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, pu, po, w);
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== vec[i] || m_axis_tuser !== exp_user[i]) begin
        n_err++;
        $display("FAIL tag[%0d]: got v=%b data=%h user=%b want v=1 data=%h user=%b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tuser, vec[i], exp_user[i]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] sent [20];
    logic [31:0] got [$];
    int idx = 0;
    logic pu, po;
    logic [33:0] w;
    for (int i = 0; i < 20; i++) sent[i] = $urandom;
    for (int c = 0; c < 24; c++) begin
      drive_cycle(1'b1, 1'b1, sent[idx], (idx == 19), 1'b0, 1'b0, pu, po, w);
      if (pu) idx++;
    end
    n_cmp++;
    if (idx != DEPTH || s_axis_result_tready !== 1'b0 || level !== (AW+1)'(DEPTH)) begin
      n_err++;
      $display("FAIL full: got accepted=%0d tready=%b level=%0d want %0d 0 %0d",
               idx, s_axis_result_tready, level, DEPTH, DEPTH);
    end
    for (int c = 0; c < 60 && got.size() < 20; c++) begin
      drive_cycle(1'b1, idx < 20, (idx < 20) ? sent[idx] : 32'h0, (idx == 19),
                  1'b1, 1'b0, pu, po, w);
      if (pu) idx++;
      if (po) got.push_back(w[31:0]);
    end
    n_cmp++;
    if (got.size() != 20) begin
      n_err++; $display("FAIL bp_count: got %0d want 20", got.size());
    end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== sent[i]) begin
        n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], sent[i]);
      end
    end
    drain();
  endtask

  task automatic test_streaming();
    int pops = 0;
    logic pu, po;
    logic [33:0] w;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b1, 1'b0, pu, po, w);
      if (po) pops++;
      if (c > 0) begin
        n_cmp++;
        if (level !== (AW+1)'(1) || m_axis_tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL stream[%0d]: got level=%0d tvalid=%b want 1 1", c, level, m_axis_tvalid);
        end
      end
    end
    n_cmp++;
    if (pops != 19) begin
      n_err++; $display("FAIL stream_rate: got %0d pops want 19", pops);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic pu, po;
    logic [33:0] w;
    for (int i = 0; i < 7; i++)
      drive_cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, pu, po, w);
    drive_cycle(1'b0, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, pu, po, w);
    n_cmp++;
    if (level !== (AW+1)'(7)) begin
      n_err++; $display("FAIL pre_reset_level: got %0d want 7", level);
    end
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pu, po, w);
    n_cmp++;
    if (level !== '0 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got level=%0d tvalid=%b want 0 0", level, m_axis_tvalid);
    end
    drive_cycle(1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, pu, po, w);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, pu, po, w);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0 || m_axis_tuser !== 1'b1 ||
        m_axis_tlast !== 1'b1) begin
      n_err++;
      $display("FAIL zero_after_reset: got v=%b data=%h user=%b last=%b want 1 0 1 1",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] pend;
    logic        have = 1'b0;
    logic pu, po;
    logic [33:0] w;
    for (int round = 0; round < 3; round++) begin
      err_bound = {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
      for (int c = 0; c < 150; c++) begin
        if (!have && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 7))
            0: pend = 32'h7FC00000 | {$urandom_range(0, 1) == 1, 31'h0};
            1: pend = 32'h7F800000 | {$urandom_range(0, 1) == 1, 31'h0};
            2: pend = {$urandom_range(0, 1) == 1, 31'h0};
            3: pend = err_bound | {$urandom_range(0, 1) == 1, 31'h0};
            4: pend = err_bound + 32'h1;
            5: pend = (err_bound == 0) ? 32'h0 : err_bound - 32'h1;
            default: pend = $urandom;
          endcase
          have = 1'b1;
        end
        drive_cycle(1'b1, have, have ? pend : 32'h0, have && pend[0], $urandom_range(0, 2) != 0,
                    1'b0, pu, po, w);
        if (pu) have = 1'b0;
      end
      for (int c = 0; c < 8 && have; c++) begin
        drive_cycle(1'b1, 1'b1, pend, pend[0], 1'b1, 1'b0, pu, po, w);
        if (pu) have = 1'b0;
      end
      n_cmp++;
      if (have) begin
        n_err++; $display("FAIL rand_accept_timeout: got pending want none");
      end
      have = 1'b0;
      drain();
    end
  endtask

`ifdef FP_RESULT_SINK_STATS_EN
  task automatic test_stats();
    logic [31:0] vals [5] = '{32'h00000000, 32'hBA000000, 32'h3A83126F,
                              32'h7F800000, 32'h3B000000};
    logic pu, po;
    logic [33:0] w;
    err_bound = 32'h3A83126F;
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pu, po, w);
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 1'b1, vals[i], 1'b0, 1'b0, 1'b0, pu, po, w);
    drain();
    n_cmp++;
    if (stat_in_bound !== 32'd3 || stat_out_bound !== 32'd2) begin
      n_err++;
      $display("FAIL stat_counts: got in=%0d out=%0d want 3 2", stat_in_bound, stat_out_bound);
    end
    drive_cycle(1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, pu, po, w);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, pu, po, w);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pu, po, w);
    n_cmp++;
    if (stat_in_bound !== 32'd0 || stat_out_bound !== 32'd0 || level !== '0) begin
      n_err++;
      $display("FAIL stat_clr: got in=%0d out=%0d level=%0d want 0 0 0",
               stat_in_bound, stat_out_bound, level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tag();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_random();
`ifdef FP_RESULT_SINK_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
